sram_readback_check: RTL
========================

# sram_readback_check

Sequential read-back verifier for the 32K x 32 instruction/data SRAM. On a level `check_start` request it reads every word from address 0 to 0x7FFF and compares each word against `expect_data`. It reports a mismatch count, the first failing address and data, and a 32-bit additive checksum. It drives the same SRAM port as the zero-fill initializer in the opposite direction and runs after fill or image load, in place of that initializer, through the same port mux.

## Interface
- `ADDR_W`, 15: SRAM word address width; last address is all-ones.
- `DATA_W`, 32: SRAM word width.
- `RD_LAT`, 1: SRAM read latency in cycles; legal range 1..4.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `check_start`  in  1  level request; hold high until `check_done`, then drop.
- `expect_data`  in  DATA_W  expected word; must be static during a run.
- `addr`  out  ADDR_W  SRAM read address.
- `en`  out  1  SRAM enable.
- `wr`  out  1  SRAM write strobe; constant 0.
- `rdata`  in  DATA_W  SRAM read data.
- `check_done`  out  1  run complete; results valid.
- `check_pass`  out  1  `check_done` and `err_count` == 0.
- `err_count`  out  8  mismatch count, saturating at 0xFF.
- `first_err_addr`  out  ADDR_W  address of the first mismatch.
- `first_err_data`  out  DATA_W  `rdata` of the first mismatch.
- `checksum`  out  32  sum of all returned words, modulo 2^32.

## Operation
- States: IDLE (00), RD (01), DRAIN (11), DONE (10).
- `en` = 1 in RD only. `check_done` = 1 in DONE only.
- IDLE:
  - `addr` = 0.
  - Moves to RD when `check_start` = 1.
  - On that transition, `err_count`, `first_err_*` and `checksum` clear to 0.
- RD:
  - `addr` increments by 1 each cycle.
  - At `addr` = last address, `addr` holds and the state moves to DRAIN.
- DRAIN: lasts exactly `RD_LAT` cycles, then moves to DONE.
- DONE:
  - Stays while `check_start` = 1.
  - Moves to IDLE when it drops.
  - Results hold in DONE and IDLE until the next start.
- Read pipeline:
  - A valid bit and an address shift register, depth `RD_LAT`, both loaded from `en` and `addr`.
  - When the valid bit is set at the output, `rdata` is compared and summed on that edge.
- Mismatch handling:
  - Any mismatch increments `err_count` unless it is already 0xFF.
  - If `err_count` was 0 before this edge, the mismatch also loads `first_err_addr` and `first_err_data`. Later mismatches never overwrite them.
- Abort:
  - If `check_start` falls in RD or DRAIN, the next state is IDLE and pipeline valid bits flush.
  - `check_done` never asserts for that run. Partial results hold.
- Reset:
  - Async reset at any point puts the state in IDLE, sets the pipeline invalid, and sets every output to 0.
  - `wr` is 0 always.

## Timing
- Cycle 0: IDLE samples `check_start` = 1.
- Cycles 1..32768: RD, with `addr` = cycle − 1.
- The read issued in cycle n is sampled at the end of cycle n + `RD_LAT`.
- DRAIN occupies cycles 32769..32768 + `RD_LAT`.
- `check_done` rises in cycle 32769 + `RD_LAT`: cycle 32770 for `RD_LAT` = 1.
- Results are final when `check_done` rises. No result register changes while in DONE.
- `check_done` falls 1 cycle after `check_start` falls.
- A new run needs at least 1 IDLE cycle.

## Test plan
- Zero-filled memory model, `expect_data` = 0, `RD_LAT` = 1 -> `check_done` rises at cycle 32770, `check_pass` = 1, `err_count` = 0, `checksum` = 0; `en` high for exactly 32768 cycles, `wr` = 0 throughout.
- Memory 0 except [0x1234] = 0xDEADBEEF and [0x5000] = 0x1 -> `err_count` = 2, `first_err_addr` = 0x1234, `first_err_data` = 0xDEADBEEF, `checksum` = 0xDEADBEF0, `check_pass` = 0.
- All words 0xFFFFFFFF, `expect_data` = 0 -> `err_count` saturates at 0xFF, `first_err_addr` = 0, `checksum` = 0xFFFF8000.
- `RD_LAT` = 3 with a 3-cycle memory model, [0x7FFF] = 0x5A -> last word is compared, `first_err_addr` = 0x7FFF, `check_done` rises at cycle 32772.
- Drop `check_start` at cycle 100 -> IDLE next cycle, `en` = 0, `check_done` stays 0. A restart clears the results and completes normally.
- Assert `reset_n` = 0 mid-RD -> `addr`, `en`, `err_count`, `checksum` and `check_done` go to 0 immediately. After release, with `check_start` low, the block stays in IDLE.

Source files
------------

// File: rtl/sram_readback_check_if.sv
// SRAM read/write port bundle shared by the fill and read-back engines.
interface sram_readback_check_if #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic              en;
  logic              wr;
  logic [DATA_W-1:0] rdata;

  modport master (output addr, output en, output wr, input rdata);
  modport slave  (input addr, input en, input wr, output rdata);
endinterface

// File: rtl/sram_readback_check.sv
// Sweeps the whole SRAM once per request, comparing every word against a static
// expected value and accumulating mismatch count, first failure and checksum.
module sram_readback_check #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  check_start,
  input  logic [DATA_W-1:0]     expect_data,
  sram_readback_check_if.master sram,
  output logic                  check_done,
  output logic                  check_pass,
  output logic [7:0]            err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [DATA_W-1:0]     first_err_data,
  output logic [31:0]           checksum
);

  localparam int unsigned CNT_W = 3;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RD    = 2'b01,
    S_DRAIN = 2'b11,
    S_DONE  = 2'b10
  } state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic                           en_q, en_d;
  logic                           done_q, done_d;
  logic                           pass_q, pass_d;
  logic [CNT_W-1:0]               drain_cnt_q, drain_cnt_d;
  logic [RD_LAT-1:0]              vld_q, vld_d;
  logic [RD_LAT-1:0][ADDR_W-1:0]  apipe_q, apipe_d;
  logic [7:0]                     err_q, err_d;
  logic [ADDR_W-1:0]              ferr_addr_q, ferr_addr_d;
  logic [DATA_W-1:0]              ferr_data_q, ferr_data_d;
  logic [31:0]                    sum_q, sum_d;
  logic                           clear;
  logic                           flush;
  logic                           hit;

  // Sequencer, read pipeline tracking and result accumulation
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    drain_cnt_d = '0;
    clear       = 1'b0;
    flush       = 1'b0;

    case (state_q)
      S_IDLE: begin
        addr_d = '0;
        if (check_start) begin
          state_d = S_RD;
          clear   = 1'b1;
        end
      end
      S_RD: begin
        if (!check_start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          flush   = 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (!check_start) begin
          state_d = S_IDLE;
          addr_d  = '0;
          flush   = 1'b1;
        end else if (drain_cnt_q == CNT_W'(RD_LAT - 1)) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!check_start) begin
          state_d = S_IDLE;
          addr_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    endcase

    en_d   = (state_d == S_RD);
    done_d = (state_d == S_DONE);

    vld_d      = '0;
    apipe_d    = apipe_q;
    vld_d[0]   = en_q;
    apipe_d[0] = addr_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      vld_d[i]   = vld_q[i-1];
      apipe_d[i] = apipe_q[i-1];
    end
    if (flush) begin
      vld_d = '0;
    end

    // A read result is consumed on the edge its valid bit reaches the end of the pipe
    hit         = vld_q[RD_LAT-1];
    err_d       = err_q;
    ferr_addr_d = ferr_addr_q;
    ferr_data_d = ferr_data_q;
    sum_d       = sum_q;
    if (clear) begin
      err_d       = '0;
      ferr_addr_d = '0;
      ferr_data_d = '0;
      sum_d       = '0;
    end else if (hit) begin
      sum_d = sum_q + 32'(sram.rdata);
      if (sram.rdata != expect_data) begin
        if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
        if (err_q == 8'd0) begin
          ferr_addr_d = apipe_q[RD_LAT-1];
          ferr_data_d = sram.rdata;
        end
      end
    end

    pass_d = done_d && (err_d == 8'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      drain_cnt_q <= '0;
      vld_q       <= '0;
      apipe_q     <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      sum_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      en_q        <= en_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      drain_cnt_q <= drain_cnt_d;
      vld_q       <= vld_d;
      apipe_q     <= apipe_d;
      err_q       <= err_d;
      ferr_addr_q <= ferr_addr_d;
      ferr_data_q <= ferr_data_d;
      sum_q       <= sum_d;
    end
  end

  assign sram.addr      = addr_q;
  assign sram.en        = en_q;
  assign sram.wr        = 1'b0;
  assign check_done     = done_q;
  assign check_pass     = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;
  assign checksum       = sum_q;

endmodule
